lcd_axis_frame_arbiter: RTL and testbench

Frame-granular AXI-stream arbiter that shares the single `axis_*` pixel input of `lcd_top` between two video sources (e.g. camera path and OSD/test-pattern generator). It grants one source per whole frame, regenerates frame framing (`tuser` on first pixel, `tlast` on last pixel of each line) from its own pixel/line counters, and pads a frame with zero pixels if the granted source stalls or restarts mid-frame. This keeps the LCD FIFO frame-aligned. It sits in the `clk` domain directly in front of `lcd_top`.

---
 rtl/lcd_axis_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lcd_axis_frame_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_axis_frame_arbiter.sv
// rtl/lcd_axis_frame_arbiter.sv - frame-granular two-source AXI-stream arbiter in front of lcd_top
// Grants one source per whole frame, regenerates tuser/tlast, pads stalled or broken frames with zeros.
module lcd_axis_frame_arbiter #(
  parameter int H_PIXELS = 480,
  parameter int V_LINES  = 272,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        src_en,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic              s0_tuser,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic              s1_tuser,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              grant,
  output logic              busy,
  output logic              pad_evt
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST     = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_LINES - 1);
  localparam logic [15:0]   STALL_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic              grant_n;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [15:0]       stall_cnt;

  logic              req0;
  logic              req1;
  logic              g_valid;
  logic              g_user;
  logic [DATA_W-1:0] g_data;
  logic              first_pos;
  logic              last_pos;
  logic              early_sof;
  logic              hs;

  assign req0 = src_en[0] & s0_tvalid & s0_tuser;
  assign req1 = src_en[1] & s1_tvalid & s1_tuser;

  assign g_valid = grant ? s1_tvalid : s0_tvalid;
  assign g_user  = grant ? s1_tuser  : s0_tuser;
  assign g_data  = grant ? s1_tdata  : s0_tdata;

  assign first_pos = (x_cnt == '0) && (y_cnt == '0);
  assign last_pos  = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  // A new SOF inside a frame is left unconsumed so it can open the next frame.
  assign early_sof = (state == ST_PASS) && g_valid && g_user && !first_pos;

  always_comb begin
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tuser   = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state)
      ST_IDLE: begin
        // Non-SOF beats are flushed; SOF beats wait for a grant.
        s0_tready = s0_tvalid & ~s0_tuser;
        s1_tready = s1_tvalid & ~s1_tuser;
      end
      ST_PASS: begin
        m_tdata  = g_data;
        m_tvalid = g_valid & ~early_sof;
        m_tuser  = first_pos;
        m_tlast  = (x_cnt == X_LAST);
        if (grant) begin
          s1_tready = m_tready & ~early_sof;
        end else begin
          s0_tready = m_tready & ~early_sof;
        end
      end
      ST_PAD: begin
        m_tvalid = 1'b1;
        m_tuser  = first_pos;
        m_tlast  = (x_cnt == X_LAST);
      end
      default: begin
        m_tvalid = 1'b0;
      end
    endcase
  end

  assign hs = m_tvalid & m_tready;

  always_comb begin
    state_n = state;
    grant_n = grant;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_n = ST_PASS;
          if (req0 && req1) begin
            grant_n = ~grant;
          end else begin
            grant_n = req1;
          end
        end
      end
      ST_PASS: begin
        if (hs && last_pos) begin
          state_n = ST_IDLE;
        end else if (early_sof) begin
          state_n = ST_PAD;
        end else if (!g_valid && (stall_cnt == STALL_LAST)) begin
          state_n = ST_PAD;
        end
      end
      ST_PAD: begin
        if (hs && last_pos) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= 1'b1;
      busy      <= 1'b0;
      pad_evt   <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      stall_cnt <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      busy    <= (state_n != ST_IDLE);
      pad_evt <= (state != ST_PAD) && (state_n == ST_PAD);
      if (state == ST_IDLE) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        stall_cnt <= '0;
      end else if (hs) begin
        stall_cnt <= '0;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end else if ((state == ST_PASS) && !g_valid) begin
        // Only source starvation counts; downstream backpressure never does.
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_axis_frame_arbiter.sv
// tb/tb_lcd_axis_frame_arbiter.sv - self-checking bench for lcd_axis_frame_arbiter
// Queue-based sources and sink; expected streams are built from whole-frame rules.
module tb_lcd_axis_frame_arbiter;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam int FR = H * V;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   src_en;
  logic [W-1:0] s0_tdata;
  logic         s0_tvalid;
  logic         s0_tready;
  logic         s0_tuser;
  logic [W-1:0] s1_tdata;
  logic         s1_tvalid;
  logic         s1_tready;
  logic         s1_tuser;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tuser;
  logic         m_tlast;
  logic         grant;
  logic         busy;
  logic         pad_evt;

  always #5 clk = ~clk;

  lcd_axis_frame_arbiter #(
    .H_PIXELS(H), .V_LINES(V), .DATA_W(W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_en(src_en),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tuser(s0_tuser),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tuser(s1_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .grant(grant), .busy(busy), .pad_evt(pad_evt)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         u;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         u;
    logic         l;
    logic         g;
  } obeat_t;

  beat_t  q0[$];
  beat_t  q1[$];
  obeat_t outq[$];

  int vectors = 0;
  int miscompares = 0;
  int pad_cnt, stall_seen, pops0, pops1, out_idle;
  int gap0, gap1;
  bit rnd_rdy, rnd_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input logic [W-1:0] d, input logic u);
    beat_t b;
    b.d = d;
    b.u = u;
    if (src == 0) q0.push_back(b);
    else          q1.push_back(b);
  endtask

  task automatic clear();
    q0.delete(); q1.delete(); outq.delete();
    pad_cnt = 0; stall_seen = 0; pops0 = 0; pops1 = 0; out_idle = 0;
    gap0 = 0; gap1 = 0; rnd_rdy = 0; rnd_val = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    s0_tuser = 1'b0; s1_tuser = 1'b0;
    s0_tdata = '0; s1_tdata = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear();
  endtask

  // One clock: drive after the edge, sample on the falling edge.
  task automatic cycle();
    logic v0, v1;
    obeat_t ob;
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    if (rnd_val) begin
      v0 = v0 && (($urandom_range(0, 3) != 0) || gap0 >= 3);
      v1 = v1 && (($urandom_range(0, 3) != 0) || gap1 >= 3);
    end
    gap0 = v0 ? 0 : gap0 + 1;
    gap1 = v1 ? 0 : gap1 + 1;
    s0_tvalid = v0;
    s0_tdata  = (q0.size() > 0) ? q0[0].d : '0;
    s0_tuser  = (q0.size() > 0) ? q0[0].u : 1'b0;
    s1_tvalid = v1;
    s1_tdata  = (q1.size() > 0) ? q1[0].d : '0;
    s1_tuser  = (q1.size() > 0) ? q1[0].u : 1'b0;
    m_tready  = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    @(negedge clk);
    if (s0_tvalid && s0_tready) begin void'(q0.pop_front()); pops0++; end
    if (s1_tvalid && s1_tready) begin void'(q1.pop_front()); pops1++; end
    if (m_tvalid && m_tready) begin
      ob.d = m_tdata; ob.u = m_tuser; ob.l = m_tlast; ob.g = grant;
      outq.push_back(ob);
    end
    if (pad_evt) pad_cnt++;
    if (busy && !m_tvalid && pad_cnt == 0) stall_seen++;
    if (!busy && m_tvalid) out_idle++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int nbeats, input int budget);
    int c = 0;
    while ((outq.size() < nbeats || busy) && c < budget) begin
      cycle();
      c++;
    end
    chk({tag, "_budget_expired"}, 64'(c >= budget), 64'd0);
  endtask

  // Framing is a function of beat index only: SOF on index 0, EOL every H beats.
  task automatic check_stream(input string tag, input logic [W-1:0] exp_d[$], input logic exp_g[$]);
    chk({tag, "_len"}, 64'(outq.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < outq.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(outq[i].d), 64'(exp_d[i]));
      chk($sformatf("%s_user%0d", tag, i), 64'(outq[i].u), 64'((i % FR) == 0));
      chk($sformatf("%s_last%0d", tag, i), 64'(outq[i].l), 64'((i % H) == H - 1));
      chk($sformatf("%s_grant%0d", tag, i), 64'(outq[i].g), 64'(exp_g[i / FR]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tuser"}, 64'(m_tuser), 64'd0);
    chk({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_tdata"}, 64'(m_tdata), 64'd0);
    chk({tag, "_s0_tready"}, 64'(s0_tready), 64'd0);
    chk({tag, "_s1_tready"}, 64'(s1_tready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd1);
    chk({tag, "_pad_evt"}, 64'(pad_evt), 64'd0);
  endtask

  initial begin
    logic [W-1:0] exp_d[$];
    logic         exp_g[$];
    logic [W-1:0] f0[$];
    logic [W-1:0] f1[$];
    logic [W-1:0] r;
    int           src;

    src_en = 2'b11;
    do_reset();
    check_reset_vals("reset");

    // Single source, plain frame.
    for (int i = 0; i < FR; i++) push(0, W'(i), i == 0);
    run("single", FR, 200);
    exp_d = {}; exp_g = {1'b0};
    for (int i = 0; i < FR; i++) exp_d.push_back(W'(i));
    check_stream("single", exp_d, exp_g);
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_pops", 64'(pops0), 64'(FR));

    // Both sources always requesting: whole frames alternate starting with s0.
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FR; i++) begin
        push(0, W'(32'h100 + f * 32'h80 + i), i == 0);
        push(1, W'(32'h200 + f * 32'h80 + i), i == 0);
      end
    run("rr", 4 * FR, 400);
    exp_d = {}; exp_g = {1'b0, 1'b1, 1'b0, 1'b1};
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < FR; i++)
        exp_d.push_back(W'(((f % 2) ? 32'h200 : 32'h100) + (f / 2) * 32'h80 + i));
    check_stream("rr", exp_d, exp_g);

    // Leading non-SOF beats are flushed without reaching the output.
    clear();
    for (int i = 0; i < 3; i++) push(0, W'(32'hA0 + i), 1'b0);
    for (int i = 0; i < FR; i++) push(0, W'(32'h300 + i), i == 0);
    run("flush", FR, 200);
    exp_d = {}; exp_g = {1'b0};
    for (int i = 0; i < FR; i++) exp_d.push_back(W'(32'h300 + i));
    check_stream("flush", exp_d, exp_g);
    chk("flush_pops", 64'(pops0), 64'(FR + 3));
    chk("flush_out_idle", 64'(out_idle), 64'd0);

    // Source stops after 5 beats: TIMEOUT stall cycles, then zero padding.
    clear();
    for (int i = 0; i < 5; i++) push(0, W'(32'h400 + i), i == 0);
    run("timeout", FR, 200);
    exp_d = {}; exp_g = {1'b0};
    for (int i = 0; i < FR; i++) exp_d.push_back((i < 5) ? W'(32'h400 + i) : '0);
    check_stream("timeout", exp_d, exp_g);
    chk("timeout_pad_evt", 64'(pad_cnt), 64'd1);
    chk("timeout_stall_cycles", 64'(stall_seen), 64'(TO));

    // Early SOF on s1's 3rd beat: pad the rest, then the held SOF opens a new frame.
    clear();
    push(1, 32'h500, 1'b1);
    push(1, 32'h501, 1'b0);
    for (int i = 0; i < FR; i++) push(1, W'(32'h600 + i), i == 0);
    run("early_sof", 2 * FR, 300);
    exp_d = {}; exp_g = {1'b1, 1'b1};
    exp_d.push_back(32'h500);
    exp_d.push_back(32'h501);
    for (int i = 2; i < FR; i++) exp_d.push_back('0);
    for (int i = 0; i < FR; i++) exp_d.push_back(W'(32'h600 + i));
    check_stream("early_sof", exp_d, exp_g);
    chk("early_sof_pad_evt", 64'(pad_cnt), 64'd1);
    chk("early_sof_pops", 64'(pops1), 64'(FR + 2));

    // Random backpressure and source gaps: each output frame must be a whole source frame, in order.
    clear();
    rnd_rdy = 1; rnd_val = 1;
    f0 = {}; f1 = {};
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FR; i++) begin
        r = {4'h1, 28'($urandom)};
        push(0, r, i == 0);
        f0.push_back(r);
      end
    for (int i = 0; i < FR; i++) begin
      r = {4'h2, 28'($urandom)};
      push(1, r, i == 0);
      f1.push_back(r);
    end
    run("rand", 3 * FR, 3000);
    chk("rand_len", 64'(outq.size()), 64'(3 * FR));
    for (int f = 0; f < 3 && outq.size() >= (f + 1) * FR; f++) begin
      src = (outq[f * FR].d[W-1:W-4] == 4'h1) ? 0 : 1;
      chk($sformatf("rand_f%0d_grant", f), 64'(outq[f * FR].g), 64'(src));
      for (int i = 0; i < FR; i++) begin
        r = (src == 0) ? ((f0.size() > 0) ? f0.pop_front() : '0)
                       : ((f1.size() > 0) ? f1.pop_front() : '0);
        chk($sformatf("rand_f%0d_data%0d", f, i), 64'(outq[f * FR + i].d), 64'(r));
        chk($sformatf("rand_f%0d_user%0d", f, i), 64'(outq[f * FR + i].u), 64'(i == 0));
        chk($sformatf("rand_f%0d_last%0d", f, i), 64'(outq[f * FR + i].l), 64'((i % H) == H - 1));
      end
    end
    chk("rand_s0_left", 64'(f0.size()), 64'd0);
    chk("rand_s1_left", 64'(f1.size()), 64'd0);
    chk("rand_pad_evt", 64'(pad_cnt), 64'd0);

    // Reset mid-frame: outputs return to reset values on the next edge.
    clear();
    for (int i = 0; i < FR; i++) push(0, W'(32'h700 + i), i == 0);
    for (int c = 0; c < 100 && outq.size() < 3; c++) cycle();
    chk("midrst_pre_beats", 64'(outq.size()), 64'd3);
    chk("midrst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
